// File: rtl/inference_sequencer.sv
// rtl/inference_sequencer.sv - sequences one image through layer_top and returns its prediction
module inference_sequencer #(
  parameter int N_PIXELS      = 784,
  parameter int STARTUP_DELAY = 2,
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 10,
  parameter int TIMEOUT       = 4096,
  parameter int IDX_W         = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     layer_start,
  output logic signed [DATA_W-1:0] layer_d_in,
  input  logic                     layer_done,
  input  logic [3:0]               layer_pred,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [3:0]               res_pred,
  output logic                     res_err,
  output logic [IDX_W-1:0]         res_idx,
  output logic                     busy
);

  // One counter serves both the start/delay/stream timeline and the done timeout.
  localparam int CNT_MAX = (TIMEOUT > N_PIXELS + STARTUP_DELAY) ? TIMEOUT : N_PIXELS + STARTUP_DELAY;
  localparam int CNT_W   = $clog2(CNT_MAX + 2);

  // Counter value on the last DELAY cycle, the last STREAM cycle, the last read,
  // and the WAIT_DONE cycle at which the timeout fires.
  localparam logic [CNT_W-1:0] DELAY_END  = CNT_W'(STARTUP_DELAY);
  localparam logic [CNT_W-1:0] STREAM_END = CNT_W'(STARTUP_DELAY + N_PIXELS);
  localparam logic [CNT_W-1:0] RD_END     = CNT_W'(STARTUP_DELAY + N_PIXELS - 1);
  localparam logic [CNT_W-1:0] TO_END     = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DELAY     = 3'd2,
    STREAM    = 3'd3,
    WAIT_DONE = 3'd4,
    RESULT    = 3'd5
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_p1;
  logic             rd_pending;
  logic             cap_done, cap_timeout, res_fire;

  // State and timeline counter; counter is 0 in START and on WAIT_DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      req_ready <= (state_next == IDLE);
    end
  end

  // Next state, strobes and buffer read addressing.
  always_comb begin
    state_next  = state;
    cnt_p1      = cnt + CNT_W'(1);
    cnt_next    = cnt_p1;
    layer_start = 1'b0;
    res_valid   = 1'b0;
    busy        = (state != IDLE);
    mem_rd_en   = 1'b0;
    mem_addr    = '0;
    cap_done    = 1'b0;
    cap_timeout = 1'b0;
    res_fire    = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (req_valid && req_ready) state_next = START;
      end
      START: begin
        layer_start = 1'b1;
        state_next  = DELAY;
      end
      DELAY: begin
        if (cnt == DELAY_END) state_next = STREAM;
      end
      STREAM: begin
        if (cnt == STREAM_END) begin
          state_next = WAIT_DONE;
          cnt_next   = '0;
        end
      end
      WAIT_DONE: begin
        if (layer_done) begin
          cap_done   = 1'b1;
          state_next = RESULT;
        end else if (cnt == TO_END) begin
          cap_timeout = 1'b1;
          state_next  = RESULT;
        end
      end
      RESULT: begin
        res_valid = 1'b1;
        cnt_next  = '0;
        if (res_ready) begin
          res_fire   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Reads run one cycle ahead of the registered pixel, so they may start in DELAY (or START).
    if ((state == START || state == DELAY || state == STREAM) &&
        cnt_p1 >= DELAY_END && cnt_p1 <= RD_END) begin
      mem_rd_en = 1'b1;
      mem_addr  = ADDR_W'(cnt_p1 - DELAY_END);
    end
  end

  // Pixel pipeline: buffer data lands one cycle after the strobe and is registered out, else 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending <= 1'b0;
      layer_d_in <= '0;
    end else begin
      rd_pending <= mem_rd_en;
      layer_d_in <= rd_pending ? $signed(mem_rdata) : '0;
    end
  end

  // Result registers: captured on leaving WAIT_DONE, held through RESULT, index bumps on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_pred <= 4'h0;
      res_err  <= 1'b0;
      res_idx  <= '0;
    end else begin
      if (cap_done) begin
        res_pred <= layer_pred;
        res_err  <= 1'b0;
      end else if (cap_timeout) begin
        res_pred <= 4'hF;
        res_err  <= 1'b1;
      end
      if (res_fire) res_idx <= res_idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_inference_sequencer.sv
// tb/tb_inference_sequencer.sv - self-checking bench for inference_sequencer
module tb_inference_sequencer;
  localparam int NP = 100;
  localparam int SD = 2;
  localparam int TO = 64;

  logic               clk;
  logic               rst_n;
  logic               req_valid;
  logic               req_ready;
  logic               mem_rd_en;
  logic [9:0]         mem_addr;
  logic [15:0]        mem_rdata;
  logic               layer_start;
  logic signed [15:0] layer_d_in;
  logic               layer_done;
  logic [3:0]         layer_pred;
  logic               res_valid;
  logic               res_ready;
  logic [3:0]         res_pred;
  logic               res_err;
  logic [7:0]         res_idx;
  logic               busy;

  inference_sequencer #(
    .N_PIXELS(NP), .STARTUP_DELAY(SD), .DATA_W(16), .ADDR_W(10), .TIMEOUT(TO), .IDX_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .layer_start(layer_start), .layer_d_in(layer_d_in),
    .layer_done(layer_done), .layer_pred(layer_pred),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_pred(res_pred), .res_err(res_err), .res_idx(res_idx), .busy(busy)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [15:0] img [0:1023];

  // stimulus knobs
  int          done_gap = 5;
  logic [3:0]  job_pred = 4'h7;
  bit          spur_en = 0;
  bit          b2b = 0;
  int          hs_count = 0;
  int          last_hs = 0;
  int          last_start = -1;
  int          strobes = 0;

  // model of one job's timeline
  bit          m_busy = 0;
  bit          m_fresh = 1;
  int          m_s = 0;
  int          m_res_from = -1;
  logic [7:0]  m_idx = 0;
  logic [3:0]  m_pred = 0;
  logic        m_err = 0;
  bit          e_start, e_rd, e_rv, e_ready;
  logic [9:0]  e_addr;
  logic [15:0] e_din;
  int          w_entry;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // image buffer: registered read, garbage when not strobed
  initial begin
    logic       p_en;
    logic [9:0] p_addr;
    mem_rdata = 16'hBEEF;
    forever begin
      @(negedge clk);
      p_en = mem_rd_en;
      p_addr = mem_addr;
      @(posedge clk);
      #1;
      mem_rdata = p_en ? img[p_addr] : 16'hBEEF;
    end
  end

  // layer_top stand-in: done done_gap cycles after the last pixel, optional spurious pulse in DELAY
  initial begin
    int cd, spur_cd;
    bit drop, spur_on;
    cd = -1; spur_cd = -1; drop = 0; spur_on = 0;
    layer_done = 1'b0;
    layer_pred = 4'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cd = -1; spur_cd = -1; drop = 1;
      end else begin
        if (layer_start) begin
          cd = (done_gap >= 0) ? SD + NP + done_gap : -1;
          spur_cd = spur_en ? 1 : -1;
        end
        if (res_valid) drop = 1;
      end
      @(posedge clk);
      #1;
      if (drop) begin layer_done = 1'b0; drop = 0; end
      if (spur_on) begin layer_done = 1'b0; spur_on = 0; end
      if (spur_cd > 0) begin
        spur_cd--;
        if (spur_cd == 0) begin layer_done = 1'b1; layer_pred = 4'h3; spur_on = 1; spur_cd = -1; end
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin layer_done = 1'b1; layer_pred = job_pred; cd = -1; end
      end
    end
  end

  // per-cycle compare against the timeline model
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_mem_rd_en", mem_rd_en, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_layer_start", layer_start, 0);
      check("rst_layer_d_in", {16'b0, layer_d_in}, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_pred", res_pred, 0);
      check("rst_res_err", res_err, 0);
      check("rst_res_idx", res_idx, 0);
      check("rst_busy", busy, 0);
      m_busy = 0; m_fresh = 1; m_idx = 0; m_pred = 0; m_err = 0; m_res_from = -1; strobes = 0;
    end else begin
      w_entry = m_s + SD + NP + 1;
      e_start = m_busy && cyc == m_s;
      e_rd    = m_busy && cyc >= m_s + SD - 1 && cyc <= m_s + SD + NP - 2;
      e_addr  = e_rd ? 10'(cyc - (m_s + SD - 1)) : 10'd0;
      e_din   = (m_busy && cyc >= m_s + SD + 1 && cyc <= m_s + SD + NP) ? img[cyc - (m_s + SD + 1)] : 16'd0;
      e_rv    = m_busy && m_res_from >= 0 && cyc >= m_res_from;
      e_ready = !m_busy && !m_fresh;
      check("req_ready", req_ready, e_ready);
      check("busy", busy, m_busy);
      check("layer_start", layer_start, e_start);
      check("mem_rd_en", mem_rd_en, e_rd);
      check("mem_addr", mem_addr, e_addr);
      check("layer_d_in", {16'b0, layer_d_in}, e_din);
      check("res_valid", res_valid, e_rv);
      check("res_pred", res_pred, m_pred);
      check("res_err", res_err, m_err);
      check("res_idx", res_idx, m_idx);

      if (layer_start) begin
        if (b2b && hs_count > 0) check("b2b_start_after_hs", cyc - last_hs, 2);
        last_start = cyc;
        strobes = 0;
      end
      if (mem_rd_en) strobes++;
      if (res_valid && res_ready) begin
        check("strobes_per_image", strobes, NP);
        if (b2b) check("b2b_res_idx", res_idx, hs_count & 255);
        hs_count++;
        last_hs = cyc;
      end

      m_fresh = 0;
      if (!m_busy) begin
        if (e_ready && req_valid) begin
          m_busy = 1; m_s = cyc + 1; m_res_from = -1;
        end
      end else if (m_res_from < 0) begin
        if (cyc >= w_entry) begin
          if (layer_done) begin
            m_res_from = cyc + 1; m_pred = layer_pred; m_err = 0;
          end else if (cyc == w_entry + TO) begin
            m_res_from = cyc + 1; m_pred = 4'hF; m_err = 1;
          end
        end
      end else if (e_rv && res_ready) begin
        m_busy = 0; m_idx = m_idx + 8'd1; m_res_from = -1;
      end
    end
  end

  task automatic issue_req(output int s);
    int n;
    s = -1;
    req_valid = 1'b1;
    for (n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    if (n == 5000) check("req_accept_wait", req_ready, 1);
    else s = cyc + 1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_result(output int t);
    int n;
    for (n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    if (n == 5000) check("res_valid_wait", res_valid, 1);
    t = cyc;
  endtask

  task automatic handshake();
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_busy", busy, 0);
    check("async_layer_d_in", {16'b0, layer_d_in}, 0);
    check("async_mem_rd_en", mem_rd_en, 0);
    check("async_req_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_b2b(input int count, input int gap);
    int n;
    done_gap = gap;
    job_pred = 4'hA;
    hs_count = 0;
    b2b = 1;
    res_ready = 1'b1;
    req_valid = 1'b1;
    for (n = 0; n < count * 200; n++) begin
      @(posedge clk);
      #1;
      if (hs_count >= count) break;
    end
    req_valid = 1'b0;
    res_ready = 1'b0;
    b2b = 0;
    check("b2b_results", hs_count, count);
  endtask

  initial begin
    int s, t;
    rst_n = 1'b0;
    req_valid = 1'b0;
    res_ready = 1'b0;
    for (int k = 0; k < 1024; k++) img[k] = 16'(k);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single image, pixel k = k, done 5 cycles after last pixel with class 7
    done_gap = 5; job_pred = 4'h7;
    issue_req(s);
    wait_result(t);
    check("t1_start_cycle", last_start, s);
    check("t1_res_latency", t - s, SD + NP + 6);
    check("t1_res_pred", res_pred, 4'h7);
    check("t1_res_err", res_err, 0);
    check("t1_res_idx", res_idx, 0);
    repeat (10) begin
      @(negedge clk);
      check("t1_hold_valid", res_valid, 1);
      check("t1_hold_pred", res_pred, 4'h7);
    end
    handshake();
    @(negedge clk);
    check("t1_idx_after", res_idx, 1);
    check("t1_valid_after", res_valid, 0);

    // back-to-back run on a scrambled image containing negative pixels
    for (int k = 0; k < 1024; k++) img[k] = 16'((k * 73 + 32'h8123) & 32'hFFFF);
    do_reset();
    run_b2b(100, 1);

    // no layer_done: timeout result, then a normal job
    done_gap = -1;
    issue_req(s);
    wait_result(t);
    check("to_latency", t - (s + SD + NP + 1), 65);
    check("to_res_pred", res_pred, 4'hF);
    check("to_res_err", res_err, 1);
    handshake();
    done_gap = 3; job_pred = 4'h2;
    issue_req(s);
    wait_result(t);
    check("after_to_latency", t - s, SD + NP + 4);
    check("after_to_pred", res_pred, 4'h2);
    check("after_to_err", res_err, 0);
    handshake();

    // reset while pixel 40 is on layer_d_in
    done_gap = 5; job_pred = 4'h6;
    issue_req(s);
    repeat (SD + 1 + 40) @(posedge clk);
    #1;
    check("pre_rst_pixel40", {16'b0, layer_d_in}, {16'b0, img[40]});
    do_reset();
    check("post_rst_ready", req_ready, 1);
    check("post_rst_no_start", layer_start, 0);

    // spurious layer_done during DELAY is ignored
    spur_en = 1; done_gap = 2; job_pred = 4'h9;
    issue_req(s);
    wait_result(t);
    spur_en = 0;
    check("spur_latency", t - s, SD + NP + 3);
    check("spur_res_pred", res_pred, 4'h9);
    check("spur_res_err", res_err, 0);
    check("spur_res_idx", res_idx, 0);
    handshake();

    // index wrap over 258 results
    do_reset();
    run_b2b(258, 1);
    check("wrap_final_idx", res_idx, 8'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation still running at time %0t, expected to finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
